mux16x1_read_ctrl: RTL
======================

// Module: mux16x1_read_ctrl
// PURPOSE
//  Read-side sequencer for the 2-bank x 16-word bit-cell array whose write path is
//  driven by the 1x16 wordline demux. Accepts a read request (ADR4 bank, ADR word),
//  runs a precharge / wordline / sense-enable sequence, and samples the selected
//  bank's bitline. Returns the bit to the requester over a valid/ack handshake.
// PARAMETERS
//  PRE_CYC  2  precharge duration in cycles, legal 1..15
//  WL_CYC   2  wordline-on duration before sensing, in cycles, legal 1..15
//  CNT_W    4  width of the phase down-counter; must hold max(PRE_CYC,WL_CYC)
// PORTS
//  CLK      in   1   clock, all state updates on rising edge
//  RST_N    in   1   synchronous reset, active low
//  REQ      in   1   read request; qualified by REQ_RDY
//  ADR4     in   1   bank select, 0 = bank0, 1 = bank1
//  ADR      in   4   word address within bank
//  REQ_RDY  out  1   request can be accepted this cycle
//  BL0      in   1   sensed bitline, bank0
//  BL1      in   1   sensed bitline, bank1
//  PRE      out  1   bitline precharge enable
//  WL       out  16  one-hot wordline for the read
//  WB       out  1   latched bank select driven to the array
//  SAE      out  1   sense-amp enable
//  DOUT     out  1   read data
//  DVALID   out  1   DOUT valid; held until DACK
//  DACK     in   1   requester has taken DOUT
// BEHAVIOUR
//  - FSM states: IDLE -> PRECH -> WLON -> SENSE -> DONE -> IDLE.
//  - Reset (RST_N=0 at an edge, from any state): state=IDLE; PRE, WL, WB, SAE, DOUT,
//    DVALID all 0; counter 0. Mid-operation reset aborts with no DVALID pulse.
//  - REQ_RDY = (state==IDLE) & RST_N; combinational; REQ ignored when REQ_RDY=0.
//  - Accept edge: IDLE & REQ -> latch ADR4 into WB and ADR into an internal word
//    register. Go to PRECH with counter=PRE_CYC-1. ADR/ADR4 are don't-care afterwards.
//  - PRECH: PRE=1, WL=0, SAE=0. Counter decrements each edge. At 0, go to WLON with
//    counter=WL_CYC-1.
//  - WLON: PRE=0, WL[word]=1 (exactly one bit), SAE=0. At counter 0, go to SENSE.
//  - SENSE: one cycle. WL held, SAE=1. At the closing edge DOUT <= (WB ? BL1 : BL0),
//    DVALID<=1, state=DONE.
//  - DONE: WL=0, SAE=0, PRE=0; DOUT/DVALID stable until an edge with DACK=1, then
//    DVALID<=0, state=IDLE. DOUT retains its last value after DACK.
//  - DACK outside DONE is ignored. REQ while in DONE is not accepted, even together
//    with DACK; the earliest next accept is the cycle after return to IDLE.
//  - Latency: DVALID rises PRE_CYC+WL_CYC+1 edges after the accept edge (default 5).
//    Minimum request-to-request spacing is PRE_CYC+WL_CYC+3 cycles.
//  - Invariants: PRE and any WL bit never high together. $onehot0(WL) always holds.
//    SAE high only in SENSE. WB changes only on an accept edge or reset.
//  - All outputs except REQ_RDY are registered.
// TESTING
//  1. Reset hold 3 cycles, then release -> all outputs 0, REQ_RDY=1 first cycle after.
//  2. REQ ADR4=0 ADR=5, BL0=1 -> PRE high 2 cycles, WL=16'h0020 for 3 cycles, SAE 1
//     cycle, DVALID=1 DOUT=1 on edge 5 after accept; DACK -> IDLE.
//  3. Sweep all 32 addresses with BL{ADR4} = ADR[0] -> WB=ADR4, WL=1<<ADR, DOUT=ADR[0].
//     Toggle ADR/ADR4 during each op with no effect.
//  4. Hold DACK=0 for 10 cycles in DONE -> DVALID/DOUT stable; REQ pulses meanwhile
//     are ignored; DACK+REQ same cycle -> accept only on the following cycle.
//  5. Assert RST_N=0 during WLON (ADR=15) -> next edge WL=0, state IDLE, no DVALID.
//  6. PRE_CYC=1, WL_CYC=1 build -> DVALID 3 edges after accept; invariants hold.

Source files
------------

// File: rtl/mux16x1_read_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux16x1_read_ctrl_if
//  Description : Bundle of request/response handshake and bit-cell array
//                signals for the 2-bank x 16-word read sequencer.
//                master : requester side, also owns the sensed bitlines
//                         bl0/bl1 coming back from the array.
//                slave  : the read sequencer (mux16x1_read_ctrl).
//  Signals     : req      1   read request, qualified by req_rdy
//                adr4     1   bank select (0 = bank0, 1 = bank1)
//                adr      4   word address within the bank
//                req_rdy  1   request can be accepted this cycle
//                bl0/bl1  1   sensed bitline of bank0 / bank1
//                pre      1   bitline precharge enable
//                wl       16  one-hot read wordline
//                wb       1   latched bank select driven to the array
//                sae      1   sense-amp enable
//                dout     1   read data
//                dvalid   1   dout valid, held until dack
//                dack     1   requester has taken dout
//  Revision    : 1.0  initial release
// ============================================================================
interface mux16x1_read_ctrl_if;
    logic        req;
    logic        adr4;
    logic [3:0]  adr;
    logic        req_rdy;
    logic        bl0;
    logic        bl1;
    logic        pre;
    logic [15:0] wl;
    logic        wb;
    logic        sae;
    logic        dout;
    logic        dvalid;
    logic        dack;

    modport master (
        output req, adr4, adr, bl0, bl1, dack,
        input  req_rdy, pre, wl, wb, sae, dout, dvalid
    );

    modport slave (
        input  req, adr4, adr, bl0, bl1, dack,
        output req_rdy, pre, wl, wb, sae, dout, dvalid
    );
endinterface
`default_nettype wire

// File: rtl/mux16x1_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux16x1_read_ctrl
//  Description : Read-side sequencer for a 2-bank x 16-word bit-cell array.
//                Accepts a read request (bank + word), runs a precharge,
//                wordline and sense-enable sequence, samples the selected
//                bank's bitline and returns the bit over a valid/ack
//                handshake.
//  Ports       : clk    clock, all state updates on the rising edge
//                rst_n  synchronous reset, active low
//                bus    mux16x1_read_ctrl_if.slave (request, array, response)
//  Parameters  : PRE_CYC  precharge duration in cycles (1..15)
//                WL_CYC   wordline-on cycles before sensing (1..15)
//                CNT_W    phase counter width, holds max(PRE_CYC, WL_CYC)
//  Revision    : 1.0  initial release
// ============================================================================
module mux16x1_read_ctrl #(
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 2,
    parameter int CNT_W   = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mux16x1_read_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRECH = 3'd1,
        ST_WLON  = 3'd2,
        ST_SENSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Counters are loaded with duration-1 so that a phase lasts exactly
    // its configured number of cycles including the cycle it reaches 0.
    localparam logic [CNT_W-1:0] c_pre_load = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] c_wl_load  = CNT_W'(WL_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [3:0]         word_q,  word_d;
    logic               wb_q,    wb_d;
    logic               pre_q,   pre_d;
    logic [15:0]        wl_q,    wl_d;
    logic               sae_q,   sae_d;
    logic               dout_q,  dout_d;
    logic               dvalid_q, dvalid_d;

    logic               w_req_rdy;
    logic               w_accept;
    logic               w_cnt_zero;

    // Ready is combinational and forced low while reset is asserted so a
    // requester never sees a handshake that the reset edge would discard.
    assign w_req_rdy  = (state_q == ST_IDLE) & rst_n;
    assign w_accept   = bus.req & w_req_rdy;
    assign w_cnt_zero = (cnt_q == c_cnt_zero);

    // Next-state / next-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        wb_d     = wb_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    word_d  = bus.adr;
                    wb_d    = bus.adr4;
                    cnt_d   = c_pre_load;
                    state_d = ST_PRECH;
                end
            end
            ST_PRECH: begin
                if (w_cnt_zero) begin
                    cnt_d   = c_wl_load;
                    state_d = ST_WLON;
                end else begin
                    cnt_d   = cnt_q - c_cnt_one;
                end
            end
            ST_WLON: begin
                if (w_cnt_zero) begin
                    state_d = ST_SENSE;
                end else begin
                    cnt_d   = cnt_q - c_cnt_one;
                end
            end
            ST_SENSE: begin
                // Bitlines are sampled on the edge that closes the single
                // sense-enable cycle.
                dout_d   = wb_q ? bus.bl1 : bus.bl0;
                dvalid_d = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (bus.dack) begin
                    dvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Array controls are derived from the state being entered so that they
    // come straight out of flops and line up exactly with the state.
    always_comb begin
        pre_d = (state_d == ST_PRECH);
        sae_d = (state_d == ST_SENSE);
        wl_d  = 16'h0000;
        if ((state_d == ST_WLON) || (state_d == ST_SENSE)) begin
            wl_d = 16'h0001 << word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= c_cnt_zero;
            word_q   <= 4'h0;
            wb_q     <= 1'b0;
            pre_q    <= 1'b0;
            wl_q     <= 16'h0000;
            sae_q    <= 1'b0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            wb_q     <= wb_d;
            pre_q    <= pre_d;
            wl_q     <= wl_d;
            sae_q    <= sae_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign bus.req_rdy = w_req_rdy;
    assign bus.pre     = pre_q;
    assign bus.wl      = wl_q;
    assign bus.wb      = wb_q;
    assign bus.sae     = sae_q;
    assign bus.dout    = dout_q;
    assign bus.dvalid  = dvalid_q;

endmodule
`default_nettype wire
